// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 stream front end.
// Holds the packer FSM states, the engine block width and the beat ratio.
package chacha_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_e;

    localparam int DATA_W = 512;
    localparam int ROW_W  = 128;

    // Beats of width in_w needed to fill one block of width out_w.
    function automatic int beat_ratio(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

    localparam int BEAT_RATIO = DATA_W / ROW_W;

endpackage

// File: rtl/chacha_stream_packer.sv
// Packs narrow AXI4-Stream beats into full ChaCha20 blocks (one row per beat).
// Ports: aclk/aresetn/srst, i_t* narrow sink, o_t* block-wide source.
module chacha_stream_packer
    import chacha_pkg::*;
#(
    parameter int IN_W  = ROW_W,
    parameter int OUT_W = DATA_W
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 srst,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    input  logic [IN_W-1:0]      i_tdata,
    input  logic [IN_W/8-1:0]    i_tkeep,
    input  logic                 i_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic [OUT_W-1:0]     o_tdata,
    output logic [OUT_W/8-1:0]   o_tkeep,
    output logic                 o_tlast
);

    localparam int R  = beat_ratio(OUT_W, IN_W);
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam int KW = IN_W / 8;
    localparam int OK = OUT_W / 8;

    packer_state_e    r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_rdy;

    logic [OUT_W-1:0] r_asm_data;
    logic [OK-1:0]    r_asm_keep;
    logic             r_asm_last;

    logic [OUT_W-1:0] r_out_data;
    logic [OK-1:0]    r_out_keep;
    logic             r_out_last;
    logic             r_out_valid;

    logic [OUT_W-1:0] w_blk_data;
    logic [OK-1:0]    w_blk_keep;
    logic             w_acc;
    logic             w_close;
    logic             w_drain;
    logic             w_load;
    logic             w_park;
    logic             w_xfer;

    assign w_acc   = i_tvalid & r_rdy;
    assign w_close = w_acc & (i_tlast | (r_cnt == CW'(R - 1)));
    assign w_drain = r_out_valid & o_tready;
    assign w_load  = w_close & (~r_out_valid | w_drain);
    assign w_park  = w_close & r_out_valid & ~o_tready;
    assign w_xfer  = (r_state == HOLD) & w_drain;

    // Slot j holds beat R-1-j; slots after an early TLAST stay empty.
    always_comb begin
        w_blk_data = r_asm_data;
        w_blk_keep = r_asm_keep;
        for (int j = 0; j < R; j++) begin
            if (r_cnt == CW'(R - 1 - j)) begin
                w_blk_data[j*IN_W +: IN_W] = i_tdata;
                w_blk_keep[j*KW +: KW]     = i_tkeep;
            end else if (i_tlast && (r_cnt < CW'(R - 1 - j))) begin
                w_blk_data[j*IN_W +: IN_W] = '0;
                w_blk_keep[j*KW +: KW]     = '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
        end else if (srst) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_rdy   <= 1'b1;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_acc) begin
                        r_cnt <= w_close ? '0 : r_cnt + CW'(1);
                    end
                    if (w_park) begin
                        r_state <= HOLD;
                        r_rdy   <= 1'b0;
                    end else begin
                        r_rdy   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_drain) begin
                        r_state <= FILL;
                        r_rdy   <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Assembly register: collects beats, parks a closed block in HOLD.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_asm_data <= '0;
            r_asm_keep <= '0;
            r_asm_last <= 1'b0;
        end else if (srst || w_load || w_xfer) begin
            r_asm_data <= '0;
            r_asm_keep <= '0;
            r_asm_last <= 1'b0;
        end else if (w_acc) begin
            r_asm_data <= w_blk_data;
            r_asm_keep <= w_blk_keep;
            r_asm_last <= w_park & i_tlast;
        end
    end

    // Output register: one block deep, refilled in the cycle it drains.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (srst) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_blk_data;
            r_out_keep  <= w_blk_keep;
            r_out_last  <= i_tlast;
            r_out_valid <= 1'b1;
        end else if (w_xfer) begin
            r_out_data  <= r_asm_data;
            r_out_keep  <= r_asm_keep;
            r_out_last  <= r_asm_last;
            r_out_valid <= 1'b1;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign i_tready = r_rdy;
    assign o_tvalid = r_out_valid;
    assign o_tdata  = r_out_data;
    assign o_tkeep  = r_out_keep;
    assign o_tlast  = r_out_last;

endmodule

// File: tb/tb_chacha_stream_packer.sv
// Self-checking bench for chacha_stream_packer against a byte-list model.
// Inputs change 1 ns after a rising edge; outputs are observed on falling edges.
module tb_chacha_stream_packer;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         srst = 1'b0;
    logic         i_tvalid = 1'b0;
    logic         i_tready;
    logic [127:0] i_tdata = '0;
    logic [15:0]  i_tkeep = '0;
    logic         i_tlast = 1'b0;
    logic         o_tvalid;
    logic         o_tready = 1'b0;
    logic [511:0] o_tdata;
    logic [63:0]  o_tkeep;
    logic         o_tlast;

    chacha_stream_packer dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .i_tdata  (i_tdata),
        .i_tkeep  (i_tkeep),
        .i_tlast  (i_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tkeep  (o_tkeep),
        .o_tlast  (o_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
    } blk_t;

    int       checks = 0;
    int       fails = 0;
    int       vcnt = 0;
    int       nacc = 0;
    int       nblk = 0;
    byte      cur_d[$];
    bit       cur_k[$];
    blk_t     expq[$];

    function automatic logic [127:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        cur_d.delete();
        cur_k.delete();
        expq.delete();
    endtask

    // Model: a block is a list of bytes in stream order, padded with zeros.
    always @(negedge aclk) begin
        if (aresetn && !srst) begin
            if (o_tvalid) vcnt++;
            if (o_tvalid && o_tready) begin
                nblk++;
                checks++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL block_unexpected got d=%h l=%b want none",
                             o_tdata, o_tlast);
                end else begin
                    blk_t e;
                    e = expq.pop_front();
                    if (o_tdata !== e.d || o_tkeep !== e.k || o_tlast !== e.l) begin
                        fails++;
                        $display("FAIL block_content got d=%h k=%h l=%b want d=%h k=%h l=%b",
                                 o_tdata, o_tkeep, o_tlast, e.d, e.k, e.l);
                    end
                end
            end
            if (i_tvalid && i_tready) begin
                nacc++;
                for (int b = 0; b < 16; b++) begin
                    cur_d.push_back(byte'(i_tdata[127-8*b -: 8]));
                    cur_k.push_back(i_tkeep[15-b]);
                end
                if (i_tlast || cur_d.size() == 64) begin
                    blk_t n;
                    n.d = '0;
                    n.k = '0;
                    n.l = i_tlast;
                    for (int b = 0; b < cur_d.size(); b++) begin
                        n.d[511-8*b -: 8] = cur_d[b];
                        n.k[63-b] = cur_k[b];
                    end
                    expq.push_back(n);
                    cur_d.delete();
                    cur_k.delete();
                end
            end
        end
    end

    task automatic offer(input logic [127:0] d, input logic [15:0] k,
                         input logic l);
        bit got;
        got = 1'b0;
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tkeep  = k;
        i_tlast  = l;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge aclk);
            got = i_tready;
            @(posedge aclk);
            #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL offer_timeout got i_tready=0 want 1");
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((expq.size() != 0 || o_tvalid) && c < 100) begin
            @(posedge aclk);
            #1;
            c++;
        end
        checks++;
        if (c >= 100) begin
            fails++;
            $display("FAIL drain_timeout got pending=%0d want 0", expq.size());
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({o_tvalid, o_tlast, i_tready} !== 3'b000 || o_tdata !== '0 ||
            o_tkeep !== '0) begin
            fails++;
            $display("FAIL reset_outputs got v=%b l=%b r=%b want 0",
                     o_tvalid, o_tlast, i_tready);
        end
        @(negedge aclk);
        #1;
        aresetn = 1'b1;
        checks++;
        if (i_tready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_before_edge got %b want 0", i_tready);
        end
        @(posedge aclk);
        #1;
        checks++;
        if (i_tready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_after_edge got %b want 1", i_tready);
        end
    endtask

    task automatic test_single_block();
        logic [127:0] b;
        logic [511:0] want;
        o_tready = 1'b1;
        for (int i = 0; i < 64; i++) want[511-8*i -: 8] = 8'(i);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) b[127-8*i -: 8] = 8'(16*k + i);
            offer(b, 16'hFFFF, k == 3);
            checks++;
            if (o_tvalid !== (k == 3)) begin
                fails++;
                $display("FAIL single_valid beat=%0d got %b want %b",
                         k, o_tvalid, k == 3);
            end
        end
        checks++;
        if (o_tdata !== want || o_tkeep !== '1 || o_tlast !== 1'b1) begin
            fails++;
            $display("FAIL single_block got d=%h k=%h l=%b want d=%h",
                     o_tdata, o_tkeep, o_tlast, want);
        end
        wait_idle();
    endtask

    task automatic test_early_tlast();
        logic [127:0] b;
        logic [63:0]  kw;
        b = {16{8'hAA}};
        kw = '0;
        kw[63:48] = 16'hFF00;
        o_tready = 1'b1;
        offer(b, 16'hFF00, 1'b1);
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata[511:384] !== b ||
            o_tdata[383:0] !== '0 || o_tkeep !== kw || o_tlast !== 1'b1) begin
            fails++;
            $display("FAIL early_tlast got v=%b d=%h k=%h l=%b want d=%h k=%h l=1",
                     o_tvalid, o_tdata, o_tkeep, o_tlast, {b, 384'h0}, kw);
        end
        for (int k = 0; k < 4; k++) offer(rnd_beat(), 16'hFFFF, k == 3);
        wait_idle();
        offer(rnd_beat(), 16'h0000, 1'b1);
        wait_idle();
    endtask

    task automatic test_backpressure();
        logic [127:0] beats[12];
        int idx;
        int c;
        int b0;
        bit acc;
        for (int i = 0; i < 12; i++) beats[i] = rnd_beat();
        b0 = nblk;
        idx = 0;
        o_tready = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            i_tvalid = 1'b1;
            i_tdata  = beats[idx];
            i_tkeep  = 16'hFFFF;
            i_tlast  = (idx == 11);
            @(negedge aclk);
            acc = i_tready;
            @(posedge aclk);
            #1;
            if (acc) idx++;
        end
        checks++;
        if (idx != 8 || i_tready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept got beats=%0d ready=%b want 8 0", idx, i_tready);
        end
        o_tready = 1'b1;
        c = 0;
        while (idx < 12 && c < 60) begin
            i_tvalid = 1'b1;
            i_tdata  = beats[idx];
            i_tlast  = (idx == 11);
            @(negedge aclk);
            acc = i_tready;
            @(posedge aclk);
            #1;
            if (acc) idx++;
            c++;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        wait_idle();
        checks++;
        if (nblk - b0 != 3 || idx != 12) begin
            fails++;
            $display("FAIL bp_blocks got %0d beats=%0d want 3 12", nblk - b0, idx);
        end
    endtask

    task automatic test_full_rate();
        int v0;
        int a0;
        int b0;
        o_tready = 1'b1;
        v0 = vcnt;
        a0 = nacc;
        b0 = nblk;
        for (int i = 0; i < 64; i++) begin
            i_tvalid = 1'b1;
            i_tdata  = rnd_beat();
            i_tkeep  = 16'hFFFF;
            i_tlast  = (i % 4 == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge aclk);
            #1;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        @(negedge aclk);
        #1;
        checks++;
        if (nacc - a0 != 64 || nblk - b0 != 16 || vcnt - v0 != 16) begin
            fails++;
            $display("FAIL full_rate got acc=%0d blk=%0d vcyc=%0d want 64 16 16",
                     nacc - a0, nblk - b0, vcnt - v0);
        end
        wait_idle();
    endtask

    task automatic test_mid_reset();
        int b0;
        o_tready = 1'b1;
        offer(rnd_beat(), 16'hFFFF, 1'b0);
        offer(rnd_beat(), 16'hFFFF, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({o_tvalid, o_tlast, i_tready} !== 3'b000 || o_tdata !== '0 ||
            o_tkeep !== '0) begin
            fails++;
            $display("FAIL midreset_outputs got v=%b l=%b r=%b want 0",
                     o_tvalid, o_tlast, i_tready);
        end
        @(negedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        checks++;
        if (i_tready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_ready got %b want 1", i_tready);
        end
        b0 = nblk;
        for (int k = 0; k < 4; k++) offer(rnd_beat(), 16'hFFFF, k == 3);
        wait_idle();
        checks++;
        if (nblk - b0 != 1) begin
            fails++;
            $display("FAIL midreset_blocks got %0d want 1", nblk - b0);
        end
    endtask

    task automatic test_srst();
        int v0;
        o_tready = 1'b0;
        for (int k = 0; k < 8; k++) offer(rnd_beat(), 16'hFFFF, 1'b0);
        @(posedge aclk);
        #1;
        checks++;
        if (i_tready !== 1'b0 || o_tvalid !== 1'b1) begin
            fails++;
            $display("FAIL srst_hold got r=%b v=%b want 0 1", i_tready, o_tvalid);
        end
        srst = 1'b1;
        @(posedge aclk);
        #1;
        srst = 1'b0;
        model_clear();
        checks++;
        if (o_tvalid !== 1'b0 || i_tready !== 1'b1 || o_tdata !== '0) begin
            fails++;
            $display("FAIL srst_clear got v=%b r=%b want 0 1", o_tvalid, i_tready);
        end
        o_tready = 1'b1;
        v0 = vcnt;
        repeat (8) @(posedge aclk);
        #1;
        checks++;
        if (vcnt != v0) begin
            fails++;
            $display("FAIL srst_stale got %0d valid cycles want 0", vcnt - v0);
        end
        for (int k = 0; k < 4; k++) offer(rnd_beat(), 16'hFFFF, k == 3);
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_early_tlast();
        test_backpressure();
        test_full_rate();
        test_mid_reset();
        test_srst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
